// File: rtl/tile_map_scheduler.sv
// Live Bomberman tile map: draw read port, collision queries, blast marking and burn-out sweep.
// Build option: define BLAST_PIERCE_EN to let blast arms pass through bricks.
module tile_map_scheduler #(
    parameter int ROWS         = 11,
    parameter int COLS         = 17,
    parameter int BLAST_RADIUS = 2,
    parameter int BURN_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] drawRow,
    input  logic [4:0] drawCol,
    output logic [1:0] drawTile,
    input  logic       qReq,
    input  logic [3:0] qRow,
    input  logic [4:0] qCol,
    output logic       qAck,
    output logic [1:0] qTile,
    input  logic       blastReq,
    input  logic [3:0] blastRow,
    input  logic [4:0] blastCol,
    output logic       blastBusy,
    output logic       blastDone,
    output logic [7:0] bricksLeft
);

    localparam logic [1:0] T_EMPTY  = 2'b00;
    localparam logic [1:0] T_PILLAR = 2'b01;
    localparam logic [1:0] T_BRICK  = 2'b10;
    localparam logic [1:0] T_BURN   = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CENTER = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_SWEEP  = 3'd4;

    localparam int STEP_W = $clog2(BLAST_RADIUS + 1);
    localparam int BURN_W = $clog2(BURN_FRAMES + 1);

`ifdef BLAST_PIERCE_EN
    localparam bit PIERCE = 1'b1;
`else
    localparam bit PIERCE = 1'b0;
`endif

    function automatic logic [1:0] reset_tile(input int r, input int c);
        if ((r % 2 == 0) && (c % 2 == 0))
            return T_PILLAR;
        if ((r % 2 == 1) && (c % 2 == 1) && !(r == 1 && c == 1) && !(r == ROWS - 2 && c == COLS - 2))
            return T_BRICK;
        return T_EMPTY;
    endfunction

    function automatic int count_bricks();
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (reset_tile(r, c) == T_BRICK) n++;
        return n;
    endfunction

    localparam int INIT_BRICKS = count_bricks();

    logic [1:0]        map_q [ROWS][COLS];
    logic [2:0]        state_q, state_d;
    logic [3:0]        bomb_row_q, bomb_row_d;
    logic [4:0]        bomb_col_q, bomb_col_d;
    logic [1:0]        dir_q, dir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              marked_q, marked_d;
    logic [3:0]        sw_row_q, sw_row_d;
    logic [4:0]        sw_col_q, sw_col_d;
    logic [BURN_W-1:0] burn_q, burn_d;
    logic              burn_act_q, burn_act_d;
    logic [7:0]        bricks_q, bricks_d;
    logic [1:0]        draw_q;
    logic              qack_q, qack_d;
    logic [1:0]        qtile_q, qtile_d;

    logic              wr_en;
    logic [3:0]        wr_row;
    logic [4:0]        wr_col;
    logic [1:0]        wr_val;

    logic [7:0]        tgt_row, tgt_col;
    logic              tgt_in;
    logic [1:0]        tgt_tile;
    logic              q_in, bomb_in;

    // Tile reached by the current arm step; off-map reads as a pillar so the arm stops.
    always_comb begin
        tgt_row = 8'(bomb_row_q);
        tgt_col = 8'(bomb_col_q);
        case (dir_q)
            2'd0:    tgt_row = 8'(bomb_row_q) - 8'(step_q);
            2'd1:    tgt_row = 8'(bomb_row_q) + 8'(step_q);
            2'd2:    tgt_col = 8'(bomb_col_q) - 8'(step_q);
            default: tgt_col = 8'(bomb_col_q) + 8'(step_q);
        endcase
        tgt_in   = (tgt_row < 8'(ROWS)) && (tgt_col < 8'(COLS));
        tgt_tile = tgt_in ? map_q[tgt_row[3:0]][tgt_col[4:0]] : T_PILLAR;
    end

    assign q_in    = (qRow < 4'(ROWS)) && (qCol < 5'(COLS));
    assign bomb_in = (bomb_row_q < 4'(ROWS)) && (bomb_col_q < 5'(COLS));

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        bomb_row_d = bomb_row_q;
        bomb_col_d = bomb_col_q;
        dir_d      = dir_q;
        step_d     = step_q;
        marked_d   = marked_q;
        sw_row_d   = sw_row_q;
        sw_col_d   = sw_col_q;
        burn_d     = burn_q;
        burn_act_d = burn_act_q;
        bricks_d   = bricks_q;
        qack_d     = 1'b0;
        qtile_d    = qtile_q;
        wr_en      = 1'b0;
        wr_row     = tgt_row[3:0];
        wr_col     = tgt_col[4:0];
        wr_val     = T_BURN;

        if (startOfFrame && (burn_q != '0) && (state_q != S_SWEEP))
            burn_d = burn_q - BURN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (burn_act_q && (burn_q == '0)) begin
                    state_d    = S_SWEEP;
                    burn_act_d = 1'b0;
                    sw_row_d   = '0;
                    sw_col_d   = '0;
                end else if (blastReq) begin
                    state_d    = S_CENTER;
                    bomb_row_d = blastRow;
                    bomb_col_d = blastCol;
                    marked_d   = 1'b0;
                end else if (qReq && !qack_q) begin
                    // The requester still holds qReq during the ack cycle; serve it only once.
                    qack_d  = 1'b1;
                    qtile_d = q_in ? map_q[qRow][qCol] : T_PILLAR;
                end
            end
            S_CENTER: begin
                state_d = S_ARM;
                dir_d   = 2'd0;
                step_d  = STEP_W'(1);
                wr_row  = bomb_row_q;
                wr_col  = bomb_col_q;
                if (bomb_in && (map_q[bomb_row_q][bomb_col_q] == T_BRICK)) begin
                    wr_en    = 1'b1;
                    marked_d = 1'b1;
                end
            end
            S_ARM: begin
                if (tgt_tile == T_BRICK) begin
                    wr_en    = 1'b1;
                    marked_d = 1'b1;
                end
                if ((tgt_tile == T_PILLAR) || ((tgt_tile == T_BRICK) && !PIERCE) ||
                    (step_q == STEP_W'(BLAST_RADIUS))) begin
                    step_d = STEP_W'(1);
                    dir_d  = dir_q + 2'd1;
                    if (dir_q == 2'd3)
                        state_d = S_DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (marked_q) begin
                    burn_d     = BURN_W'(BURN_FRAMES);
                    burn_act_d = 1'b1;
                end
            end
            S_SWEEP: begin
                wr_row = sw_row_q;
                wr_col = sw_col_q;
                wr_val = T_EMPTY;
                if (map_q[sw_row_q][sw_col_q] == T_BURN) begin
                    wr_en = 1'b1;
                    if (bricks_q != 8'd0)
                        bricks_d = bricks_q - 8'd1;
                end
                if (sw_col_q == 5'(COLS - 1)) begin
                    sw_col_d = '0;
                    if (sw_row_q == 4'(ROWS - 1)) begin
                        sw_row_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        sw_row_d = sw_row_q + 4'd1;
                    end
                end else begin
                    sw_col_d = sw_col_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the map must reload its default layout on reset, so it is held in flops, not an inferred RAM.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    map_q[r][c] <= reset_tile(r, c);
        end else if (wr_en) begin
            map_q[wr_row][wr_col] <= wr_val;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            bomb_row_q <= '0;
            bomb_col_q <= '0;
            dir_q      <= '0;
            step_q     <= STEP_W'(1);
            marked_q   <= 1'b0;
            sw_row_q   <= '0;
            sw_col_q   <= '0;
            burn_q     <= '0;
            burn_act_q <= 1'b0;
            bricks_q   <= 8'(INIT_BRICKS);
            draw_q     <= T_EMPTY;
            qack_q     <= 1'b0;
            qtile_q    <= T_EMPTY;
        end else begin
            state_q    <= state_d;
            bomb_row_q <= bomb_row_d;
            bomb_col_q <= bomb_col_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            marked_q   <= marked_d;
            sw_row_q   <= sw_row_d;
            sw_col_q   <= sw_col_d;
            burn_q     <= burn_d;
            burn_act_q <= burn_act_d;
            bricks_q   <= bricks_d;
            draw_q     <= ((drawRow < 4'(ROWS)) && (drawCol < 5'(COLS))) ? map_q[drawRow][drawCol] : T_EMPTY;
            qack_q     <= qack_d;
            qtile_q    <= qtile_d;
        end
    end

    assign drawTile   = draw_q;
    assign qAck       = qack_q;
    assign qTile      = qtile_q;
    assign blastBusy  = (state_q != S_IDLE);
    assign blastDone  = (state_q == S_DONE);
    assign bricksLeft = bricks_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Randomised scoreboard bench for tile_map_scheduler against a tile-level model of the playfield.
module tb_tile_map_scheduler;

    localparam int ROWS        = 11;
    localparam int COLS        = 17;
    localparam int BURN_FRAMES = 30;
`ifdef BLAST_PIERCE_EN
    localparam int R      = 4;
    localparam bit PIERCE = 1'b1;
`else
    localparam int R      = 2;
    localparam bit PIERCE = 1'b0;
`endif

    logic       clk, resetN, startOfFrame;
    logic [3:0] drawRow, qRow, blastRow;
    logic [4:0] drawCol, qCol, blastCol;
    logic [1:0] drawTile, qTile;
    logic       qReq, qAck, blastReq, blastBusy, blastDone;
    logic [7:0] bricksLeft;

    tile_map_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .BLAST_RADIUS(R), .BURN_FRAMES(BURN_FRAMES)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .drawRow(drawRow), .drawCol(drawCol), .drawTile(drawTile),
        .qReq(qReq), .qRow(qRow), .qCol(qCol), .qAck(qAck), .qTile(qTile),
        .blastReq(blastReq), .blastRow(blastRow), .blastCol(blastCol),
        .blastBusy(blastBusy), .blastDone(blastDone), .bricksLeft(bricksLeft)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic flag(input string name);
        n_checks++;
        $display("FAIL %s: expected event did not occur as required", name);
    endtask

    // ---------------- reference model: tile codes 0 empty, 1 pillar, 2 brick, 3 burning
    int mmap [ROWS][COLS];
    int m_bricks, m_burn;
    bit m_active;

    function automatic int spec_tile(input int r, input int c);
        if (r % 2 == 0 && c % 2 == 0) return 1;
        if (r % 2 == 1 && c % 2 == 1 && !(r == 1 && c == 1) && !(r == ROWS - 2 && c == COLS - 2)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_bricks = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mmap[r][c] = spec_tile(r, c);
                if (mmap[r][c] == 2) m_bricks++;
            end
        m_burn   = 0;
        m_active = 1'b0;
    endtask

    task automatic model_blast(input int br, input int bc, output int steps, output bit marked);
        int r, c, dr, dc;
        bit stop;
        steps  = 0;
        marked = 1'b0;
        if (mmap[br][bc] == 2) begin
            mmap[br][bc] = 3;
            marked = 1'b1;
        end
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? -1 : (d == 1) ? 1 : 0;
            dc = (d == 2) ? -1 : (d == 3) ? 1 : 0;
            stop = 1'b0;
            for (int s = 1; s <= R && !stop; s++) begin
                r = br + dr * s;
                c = bc + dc * s;
                steps++;
                if (r < 0 || r >= ROWS || c < 0 || c >= COLS) stop = 1'b1;
                else if (mmap[r][c] == 1) stop = 1'b1;
                else if (mmap[r][c] == 2) begin
                    mmap[r][c] = 3;
                    marked = 1'b1;
                    if (!PIERCE) stop = 1'b1;
                end
            end
        end
        if (marked) begin
            m_burn   = BURN_FRAMES;
            m_active = 1'b1;
        end
    endtask

    task automatic model_sweep();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mmap[r][c] == 3) begin
                    mmap[r][c] = 0;
                    if (m_bricks > 0) m_bricks--;
                end
    endtask

    // ---------------- scoreboard queues and monitor
    typedef struct {
        int dur;
        int bricks;
    } blast_exp_t;

    int         draw_exp_q [$];
    int         query_exp_q[$];
    blast_exp_t blast_exp_q[$];
    int         sweep_exp_q[$];

    logic draw_req, draw_chk;
    bit   tally_en;
    int   n_pil, n_brk;
    int   busy_run, mon_e;
    bit   prev_busy, saw_done;
    blast_exp_t mon_be;

    always @(posedge clk) draw_chk <= draw_req;

    always @(negedge clk) begin
        if (!resetN) begin
            busy_run  = 0;
            prev_busy = 1'b0;
            saw_done  = 1'b0;
        end else begin
            if (draw_chk) begin
                if (draw_exp_q.size() == 0) flag("draw_unexpected");
                else begin
                    mon_e = draw_exp_q.pop_front();
                    check("drawTile", drawTile, mon_e);
                    if (tally_en && drawTile == 2'b01) n_pil++;
                    if (tally_en && drawTile == 2'b10) n_brk++;
                end
            end
            if (qAck) begin
                check("qAck_only_in_idle", blastBusy, 0);
                if (query_exp_q.size() == 0) flag("qAck_unexpected");
                else begin
                    mon_e = query_exp_q.pop_front();
                    check("qTile", qTile, mon_e);
                end
            end
            if (blastBusy) busy_run++;
            if (blastDone) begin
                saw_done = 1'b1;
                if (blast_exp_q.size() == 0) flag("blastDone_unexpected");
                else begin
                    mon_be = blast_exp_q.pop_front();
                    check("blast_cycles", busy_run, mon_be.dur);
                    check("bricksLeft_at_blastDone", bricksLeft, mon_be.bricks);
                end
            end
            if (!blastBusy && prev_busy) begin
                if (!saw_done) begin
                    if (sweep_exp_q.size() == 0) flag("sweep_unexpected");
                    else begin
                        mon_e = sweep_exp_q.pop_front();
                        check("sweep_cycles", busy_run, ROWS * COLS);
                        check("bricksLeft_after_sweep", bricksLeft, mon_e);
                    end
                end
                saw_done = 1'b0;
            end
            if (!blastBusy) busy_run = 0;
            prev_busy = blastBusy;
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic draw_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                drawRow  = 4'(r);
                drawCol  = 5'(c);
                draw_req = 1'b1;
                draw_exp_q.push_back(mmap[r][c]);
                tick();
            end
        drawRow = 4'(ROWS); drawCol = 5'd0;      draw_exp_q.push_back(0); tick();
        drawRow = 4'd0;     drawCol = 5'(COLS);  draw_exp_q.push_back(0); tick();
        drawRow = 4'd15;    drawCol = 5'd31;     draw_exp_q.push_back(0); tick();
        draw_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_query(input int r, input int c);
        int n;
        query_exp_q.push_back((r < ROWS && c < COLS) ? mmap[r][c] : 1);
        qRow = 4'(r);
        qCol = 5'(c);
        qReq = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!qAck && n < 10);
        if (!qAck) flag("query_timeout");
        tick();
        qReq = 1'b0;
    endtask

    task automatic do_blast(input int r, input int c, input bit with_q, input int qr, input int qc);
        int steps, n;
        bit marked;
        blast_exp_t be;
        model_blast(r, c, steps, marked);
        be.dur    = steps + 2;
        be.bricks = m_bricks;
        blast_exp_q.push_back(be);
        blastRow = 4'(r);
        blastCol = 5'(c);
        blastReq = 1'b1;
        if (with_q) begin
            query_exp_q.push_back((qr < ROWS && qc < COLS) ? mmap[qr][qc] : 1);
            qRow = 4'(qr);
            qCol = 5'(qc);
            qReq = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!blastDone && n < 64);
        if (!blastDone) flag("blast_timeout");
        tick();
        blastReq = 1'b0;
        if (with_q) begin
            @(negedge clk);
            check("busy_low_after_done", blastBusy, 0);
            check("qAck_not_yet", qAck, 0);
            @(negedge clk);
            check("qAck_one_cycle_after_busy", qAck, 1);
            tick();
            qReq = 1'b0;
        end
    endtask

    task automatic send_frame();
        int n;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        if (m_burn > 0) m_burn--;
        if (m_active && m_burn == 0) begin
            m_active = 1'b0;
            model_sweep();
            sweep_exp_q.push_back(m_bricks);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!blastBusy && n < 8);
            if (!blastBusy) flag("sweep_start_timeout");
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (blastBusy && n < ROWS * COLS + 20);
            if (blastBusy) flag("sweep_end_timeout");
        end
    endtask

    // ---------------- main sequence
    initial begin
        resetN = 1'b0; startOfFrame = 1'b0;
        drawRow = '0; drawCol = '0; draw_req = 1'b0;
        qReq = 1'b0; qRow = '0; qCol = '0;
        blastReq = 1'b0; blastRow = '0; blastCol = '0;
        tally_en = 1'b0; n_pil = 0; n_brk = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_drawTile", drawTile, 0);
        check("reset_qAck", qAck, 0);
        check("reset_qTile", qTile, 0);
        check("reset_blastBusy", blastBusy, 0);
        check("reset_blastDone", blastDone, 0);
        check("reset_bricksLeft", bricksLeft, 38);
        resetN = 1'b1;
        tick();

        tally_en = 1'b1;
        draw_all();
        tally_en = 1'b0;
        check("pillar_count", n_pil, 54);
        check("brick_count", n_brk, 38);

        // Blast beside the start corner, then let it burn out.
        do_blast(1, 2, 1'b0, 0, 0);
        draw_all();
        repeat (BURN_FRAMES) send_frame();
        check("bricksLeft_model_after_first_sweep", bricksLeft, m_bricks);
        check("busy_low_after_sweep", blastBusy, 0);
        draw_all();

        // Simultaneous blast and query: blast wins, query follows.
        do_blast(3, 3, 1'b1, 0, 0);
        do_query(12, 0);
        do_query(0, 0);
        do_query(3, 3);
        do_query(5, 17);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                do_blast(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)), 1'b0, 0, 0);
                repeat ($urandom_range(0, 12)) send_frame();
            end else begin
                do_query(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
            end
        end
        while (m_active) send_frame();
        draw_all();
        check("bricksLeft_after_random", bricksLeft, m_bricks);

        // Asynchronous reset in the middle of an arm walk.
        blastRow = 4'd5;
        blastCol = 5'd5;
        blastReq = 1'b1;
        tick();
        tick();
        #2;
        resetN = 1'b0;
        #1;
        blastReq = 1'b0;
        check("midblast_reset_busy", blastBusy, 0);
        check("midblast_reset_done", blastDone, 0);
        check("midblast_reset_bricks", bricksLeft, 38);
        check("midblast_reset_drawTile", drawTile, 0);
        model_reset();
        tick();
        resetN = 1'b1;
        tick();
        draw_all();
        check("bricksLeft_after_release", bricksLeft, 38);

        check("draw_queue_drained", draw_exp_q.size(), 0);
        check("query_queue_drained", query_exp_q.size(), 0);
        check("blast_queue_drained", blast_exp_q.size(), 0);
        check("sweep_queue_drained", sweep_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
